keypad_scanner: RTL and testbench

Scans a 4x4 matrix keypad and reports the identity of one pressed key as a 4-bit hex code plus a raw `key_pressed` level. It sits directly upstream of the keypad debouncer: its `key_code` and `key_pressed` outputs feed that stage's `sig_in` and `key_pressed` inputs. The scanner does no debouncing; contact bounce appears on `key_pressed`, and downstream filtering removes it.

---
 rtl/keypad_pkg.sv | 38 +++
 rtl/keypad_scanner_sync2.sv | 26 ++
 rtl/keypad_scanner.sv | 105 ++++++++++
 tb/tb_keypad_scanner.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad scanner and its downstream debouncer.
// Latency: none (declarations and pure functions only).
// Backpressure: not applicable.
package keypad_pkg;

  typedef enum logic {
    SCAN = 1'b0,
    HELD = 1'b1
  } scan_state_t;

  // Column drive value while column 0 is selected (active-low one-hot).
  localparam logic [3:0] COLS_RESET = 4'b1110;

  // Hex code for each key, indexed by {row, col}; index 0 is row 0 / col 0.
  localparam logic [15:0][3:0] KEY_MAP = {
    4'hD, 4'hF, 4'h0, 4'hE,   // row 3: cols 3..0
    4'hC, 4'h9, 4'h8, 4'h7,   // row 2
    4'hB, 4'h6, 4'h5, 4'h4,   // row 1
    4'hA, 4'h3, 4'h2, 4'h1    // row 0
  };

  // Lowest-index zero bit; when several rows are low in the same column the
  // lowest row wins. Only called when at least one bit is zero.
  function automatic logic [1:0] lowest_zero(input logic [3:0] v);
    logic [1:0] idx;
    if (!v[0])      idx = 2'd0;
    else if (!v[1]) idx = 2'd1;
    else if (!v[2]) idx = 2'd2;
    else            idx = 2'd3;
    return idx;
  endfunction

  // Active-low one-hot column drive for a column index.
  function automatic logic [3:0] col_drive(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/keypad_scanner_sync2.sv
// Two-flop synchronizer for asynchronous level inputs; resets to all ones.
// Latency: 2 clk cycles from d to q.
// Backpressure: none; samples every cycle.
module sync2 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // Two-stage capture; reset value all ones reads as "no key pressed".
  always_ff @(posedge clk) begin
    if (!reset) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// Scans a 4x4 matrix keypad, latches one pressed key's hex code and a raw pressed level.
// Latency: detect <= 2 + 4*SETTLE_CYCLES cycles; release 3 cycles; all outputs registered.
// Backpressure: none; the downstream debouncer samples key_code/key_pressed freely.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4800
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] key_code,
  output logic       key_pressed
);

  localparam int              CNT_W    = $clog2(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  logic [3:0]       rows_s;
  scan_state_t      state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [1:0]       col_idx, col_nxt;
  logic [1:0]       row_idx, row_nxt;
  logic [3:0]       cols_nxt;
  logic [3:0]       code_nxt;
  logic             pressed_nxt;
  logic [1:0]       hit_row;

  sync2 #(.WIDTH(4)) u_rows_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rows),
    .q     (rows_s)
  );

  assign hit_row = lowest_zero(rows_s);

  // Next-state and output logic: sample rows at the end of each settle window,
  // then hold the latched key until its row line goes high again.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    col_nxt     = col_idx;
    row_nxt     = row_idx;
    code_nxt    = key_code;
    pressed_nxt = key_pressed;
    case (state)
      SCAN: begin
        if (cnt == CNT_LAST) begin
          cnt_nxt = '0;
          if (&rows_s) begin
            col_nxt = col_idx + 2'd1;
          end else begin
            row_nxt     = hit_row;
            code_nxt    = KEY_MAP[{hit_row, col_idx}];
            pressed_nxt = 1'b1;
            state_nxt   = HELD;
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      HELD: begin
        cnt_nxt = '0;
        // Any high on the latched row ends the hold, including a bounce;
        // scanning restarts on the next column.
        if (rows_s[row_idx]) begin
          pressed_nxt = 1'b0;
          col_nxt     = col_idx + 2'd1;
          state_nxt   = SCAN;
        end
      end
      default: begin
        state_nxt = SCAN;
        cnt_nxt   = '0;
      end
    endcase
    // Column drive is registered alongside col_idx so it moves on the same
    // edge that clears cnt.
    cols_nxt = col_drive(col_nxt);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= SCAN;
      cnt         <= '0;
      col_idx     <= 2'd0;
      row_idx     <= 2'd0;
      cols        <= COLS_RESET;
      key_code    <= 4'h0;
      key_pressed <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      col_idx     <= col_nxt;
      row_idx     <= row_nxt;
      cols        <= cols_nxt;
      key_code    <= code_nxt;
      key_pressed <= pressed_nxt;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a column-aware keypad model.
// Latency: checks detection bound, exact release timing and column stepping.
// Backpressure: not applicable.
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] rows;
  logic [3:0] cols;
  logic [3:0] key_code;
  logic       key_pressed;

  // Keypad model state: one bit per key, index = row*4 + col.
  logic [15:0] pressed;
  logic [3:0]  glitch;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [3:0] key;
    logic [3:0] code;
    logic [3:0] cols_held;
    logic [3:0] cols_after;
  } vec_t;

  vec_t vecs[16];

  keypad_scanner #(.SETTLE_CYCLES(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .rows        (rows),
    .cols        (cols),
    .key_code    (key_code),
    .key_pressed (key_pressed)
  );

  always #5 clk = ~clk;

  // A row reads low only while a pressed key's column is being driven low.
  always_comb begin
    logic [3:0] r_m;
    r_m = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !cols[c]) r_m[r] = 1'b0;
    rows = r_m | glitch;
  end

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Wait up to 2 + 4*8 = 34 edges for key_pressed to rise.
  task automatic wait_detect(input string name);
    for (int i = 0; i < 34; i++) begin
      if (key_pressed) break;
      step(1);
    end
    check(name, {3'b000, key_pressed}, 4'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic hold_ok;

    vecs[0]  = '{4'd0,  4'h1, 4'b1110, 4'b1101};
    vecs[1]  = '{4'd1,  4'h2, 4'b1101, 4'b1011};
    vecs[2]  = '{4'd2,  4'h3, 4'b1011, 4'b0111};
    vecs[3]  = '{4'd3,  4'hA, 4'b0111, 4'b1110};
    vecs[4]  = '{4'd4,  4'h4, 4'b1110, 4'b1101};
    vecs[5]  = '{4'd5,  4'h5, 4'b1101, 4'b1011};
    vecs[6]  = '{4'd6,  4'h6, 4'b1011, 4'b0111};
    vecs[7]  = '{4'd7,  4'hB, 4'b0111, 4'b1110};
    vecs[8]  = '{4'd8,  4'h7, 4'b1110, 4'b1101};
    vecs[9]  = '{4'd9,  4'h8, 4'b1101, 4'b1011};
    vecs[10] = '{4'd10, 4'h9, 4'b1011, 4'b0111};
    vecs[11] = '{4'd11, 4'hC, 4'b0111, 4'b1110};
    vecs[12] = '{4'd12, 4'hE, 4'b1110, 4'b1101};
    vecs[13] = '{4'd13, 4'h0, 4'b1101, 4'b1011};
    vecs[14] = '{4'd14, 4'hF, 4'b1011, 4'b0111};
    vecs[15] = '{4'd15, 4'hD, 4'b0111, 4'b1110};

    reset   = 1'b0;
    pressed = '0;
    glitch  = '0;

    // Reset values and idle column stepping.
    step(3);
    check("rst_cols", cols, 4'b1110);
    check("rst_pressed", {3'b000, key_pressed}, 4'h0);
    check("rst_code", key_code, 4'h0);
    reset = 1'b1;
    step(7);
    check("idle_col0_held", cols, 4'b1110);
    step(1);
    check("idle_col1", cols, 4'b1101);
    step(8);
    check("idle_col2", cols, 4'b1011);
    step(8);
    check("idle_col3", cols, 4'b0111);
    step(8);
    check("idle_wrap", cols, 4'b1110);

    // Every key: detect, frozen column, exact 3-cycle release, column advance.
    for (int i = 0; i < 16; i++) begin
      pressed = 16'b1 << vecs[i].key;
      wait_detect($sformatf("key%0d_detect", i));
      check($sformatf("key%0d_code", i), key_code, vecs[i].code);
      check($sformatf("key%0d_cols_held", i), cols, vecs[i].cols_held);
      pressed = '0;
      step(2);
      check($sformatf("key%0d_still", i), {3'b000, key_pressed}, 4'h1);
      step(1);
      check($sformatf("key%0d_release", i), {3'b000, key_pressed}, 4'h0);
      check($sformatf("key%0d_code_kept", i), key_code, vecs[i].code);
      check($sformatf("key%0d_cols_after", i), cols, vecs[i].cols_after);
    end

    // Same-column conflict: r1/c0 and r3/c0 together, lowest row wins.
    pressed = (16'b1 << 4) | (16'b1 << 12);
    wait_detect("conflict_detect");
    check("conflict_code", key_code, 4'h4);
    pressed = 16'b1 << 12;
    step(3);
    check("conflict_release", {3'b000, key_pressed}, 4'h0);
    wait_detect("conflict_redetect");
    check("conflict_code2", key_code, 4'hE);
    check("conflict_cols2", cols, 4'b1110);
    pressed = '0;
    step(3);

    // No rollover: second key during HELD is ignored.
    pressed = 16'b1 << 2;
    wait_detect("noroll_detect");
    check("noroll_code", key_code, 4'h3);
    pressed = pressed | 16'b1;
    hold_ok = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (key_code !== 4'h3 || cols !== 4'b1011 || key_pressed !== 1'b1) hold_ok = 1'b0;
    end
    check("noroll_hold", {3'b000, hold_ok}, 4'h1);
    pressed = 16'b1;
    step(3);
    check("noroll_release", {3'b000, key_pressed}, 4'h0);
    check("noroll_cols", cols, 4'b0111);
    wait_detect("noroll_second");
    check("noroll_code2", key_code, 4'h1);
    check("noroll_cols2", cols, 4'b1110);
    pressed = '0;
    step(3);

    // Reset during HELD.
    pressed = 16'b1 << 9;
    wait_detect("rsth_detect");
    check("rsth_code", key_code, 4'h8);
    reset = 1'b0;
    step(1);
    check("rsth_cols", cols, 4'b1110);
    check("rsth_pressed", {3'b000, key_pressed}, 4'h0);
    check("rsth_code0", key_code, 4'h0);
    pressed = '0;
    step(1);
    reset = 1'b1;
    step(2);

    // Single-cycle bounce on the latched row (r2/c1).
    pressed = 16'b1 << 9;
    wait_detect("bounce_detect");
    check("bounce_code", key_code, 4'h8);
    glitch = 4'b0100;
    step(1);
    glitch = 4'b0000;
    step(1);
    check("bounce_still", {3'b000, key_pressed}, 4'h1);
    step(1);
    check("bounce_drop", {3'b000, key_pressed}, 4'h0);
    check("bounce_cols", cols, 4'b1011);
    wait_detect("bounce_redetect");
    check("bounce_code2", key_code, 4'h8);
    check("bounce_cols2", cols, 4'b1101);
    pressed = '0;
    step(3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
